// File: rtl/reg_dump_reader_if.sv
// Beat stream carrying captured register values ({addr,data}) from
// reg_dump_reader to its sink. The reader drives the master side.
interface reg_dump_reader_if #(
    parameter int RegAddrBits = 3,
    parameter int DataWidth   = 16
);
    logic                   dump_valid;
    logic                   dump_ready;
    logic [RegAddrBits-1:0] dump_addr;
    logic [DataWidth-1:0]   dump_data;
    logic                   dump_last;
    logic                   dump_sum;

    modport master (
        output dump_valid, dump_addr, dump_data, dump_last, dump_sum,
        input  dump_ready
    );

    modport slave (
        input  dump_valid, dump_addr, dump_data, dump_last, dump_sum,
        output dump_ready
    );
endinterface

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks the processor register debug port (inr -> out_value)
// over registers 0..TotalReg-1 after a start pulse, waits ReadLatency edges per
// register, and emits each captured value as a beat on a valid/ready stream.
// Optional macro DUMP_CHECKSUM_EN appends a ninth beat carrying the XOR of
// all captured values (dump_sum=1, dump_last=1, dump_addr=0).
module reg_dump_reader #(
    parameter int RegAddrBits = 3,
    parameter int DataWidth   = 16,
    parameter int TotalReg    = 8,
    parameter int ReadLatency = 1
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   start,
    input  logic                   abort,
    output logic [RegAddrBits-1:0] inr,
    input  logic [DataWidth-1:0]   out_value,
    reg_dump_reader_if.master      dump,
    output logic                   busy,
    output logic                   done
);
    localparam int CntW = (ReadLatency < 2) ? 1 : $clog2(ReadLatency + 1);
    localparam logic [CntW-1:0]        CntInit  = CntW'(ReadLatency);
    localparam logic [RegAddrBits-1:0] LastAddr = RegAddrBits'(TotalReg - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SEND,
`ifdef DUMP_CHECKSUM_EN
        S_SUM,
`endif
        S_DONE
    } state_t;

    state_t                 state, next_state;
    logic [CntW-1:0]        cnt;
    logic                   valid_q;
    logic [RegAddrBits-1:0] addr_q;
    logic [DataWidth-1:0]   data_q;
    logic                   last_q;
    logic                   accept;
    logic                   at_last;
    logic                   cnt_hit;
    logic                   aborting;

    assign accept   = valid_q & dump.dump_ready;
    assign at_last  = (inr == LastAddr);
    assign cnt_hit  = (cnt == CntW'(1));
    assign aborting = abort && (state != S_IDLE) && (state != S_DONE);

    assign dump.dump_valid = valid_q;
    assign dump.dump_addr  = addr_q;
    assign dump.dump_data  = data_q;
    assign dump.dump_last  = last_q;
    assign done            = (state == S_DONE);

`ifdef DUMP_CHECKSUM_EN
    logic                 sum_q;
    logic [DataWidth-1:0] chk_q;
    assign dump.dump_sum = sum_q;
`else
    assign dump.dump_sum = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state decode; abort wins over start and over a pending handshake
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (start && !abort) next_state = S_WAIT;
            S_WAIT: begin
                if (abort)        next_state = S_IDLE;
                else if (cnt_hit) next_state = S_SEND;
            end
            S_SEND: begin
                if (abort) next_state = S_IDLE;
                else if (accept) begin
                    if (!at_last) next_state = S_WAIT;
`ifdef DUMP_CHECKSUM_EN
                    else          next_state = S_SUM;
`else
                    else          next_state = S_DONE;
`endif
                end
            end
`ifdef DUMP_CHECKSUM_EN
            S_SUM: begin
                if (abort)       next_state = S_IDLE;
                else if (accept) next_state = S_DONE;
            end
`endif
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Scan address, latency counter, beat registers and busy flag
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            inr     <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            sum_q   <= 1'b0;
            chk_q   <= '0;
`endif
        end else if (aborting) begin
            valid_q <= 1'b0;
            busy    <= 1'b0;
            last_q  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            sum_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        inr  <= '0;
                        cnt  <= CntInit;
                        busy <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                        chk_q <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (cnt_hit) begin
                        data_q  <= out_value;
                        addr_q  <= inr;
                        valid_q <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                        last_q  <= 1'b0;
                        sum_q   <= 1'b0;
                        chk_q   <= chk_q ^ out_value;
`else
                        last_q  <= at_last;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_SEND: begin
                    if (accept) begin
                        valid_q <= 1'b0;
                        if (!at_last) begin
                            inr <= inr + 1'b1;
                            cnt <= CntInit;
                        end
`ifdef DUMP_CHECKSUM_EN
                        else begin
                            // checksum beat is loaded on the same edge that retires the last register beat
                            valid_q <= 1'b1;
                            data_q  <= chk_q;
                            addr_q  <= '0;
                            sum_q   <= 1'b1;
                            last_q  <= 1'b1;
                        end
`endif
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                S_SUM: if (accept) valid_q <= 1'b0;
`endif
                S_DONE:  busy <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader with a combinational register-file
// stub (out_value = 1 << inr). Honours DUMP_CHECKSUM_EN when defined.
module tb_reg_dump_reader;
    localparam int AW = 3;
    localparam int DW = 16;
`ifdef DUMP_CHECKSUM_EN
    localparam bit CHK = 1'b1;
    localparam int NB  = 9;
    localparam int NT  = 20;
`else
    localparam bit CHK = 1'b0;
    localparam int NB  = 8;
    localparam int NT  = 19;
`endif

    logic          CLK;
    logic          RST_N;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic [AW-1:0] inr;
    logic [DW-1:0] out_value;

    reg_dump_reader_if #(.RegAddrBits(AW), .DataWidth(DW)) dif ();

    reg_dump_reader #(
        .RegAddrBits(AW),
        .DataWidth(DW),
        .TotalReg(8),
        .ReadLatency(1)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .start(start),
        .abort(abort),
        .inr(inr),
        .out_value(out_value),
        .dump(dif.master),
        .busy(busy),
        .done(done)
    );

    assign out_value = 16'h0001 << inr;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic          start;
        logic          abort;
        logic          ready;
        logic          valid;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
        logic          sum;
        logic          busy;
        logic          done;
    } vec_t;

    vec_t tbl[20];

    logic [AW-1:0] b_addr[16];
    logic [DW-1:0] b_data[16];
    logic          b_last[16];
    logic          b_sum[16];
    int            nb;
    int            nd;

    function automatic vec_t mk(bit s, bit a, bit r, bit v, int ad, int d,
                                bit l, bit sm, bit b, bit dn);
        vec_t t;
        t.start = s;  t.abort = a;  t.ready = r;  t.valid = v;
        t.addr  = AW'(ad);
        t.data  = DW'(d);
        t.last  = l;  t.sum = sm;  t.busy = b;  t.done = dn;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Expected beat i of a full dump
    function automatic logic [AW-1:0] e_addr(int i);
        return (i < 8) ? AW'(i) : '0;
    endfunction
    function automatic logic [DW-1:0] e_data(int i);
        return (i < 8) ? DW'(1 << i) : 16'h00FF;
    endfunction
    function automatic logic e_last(int i);
        return (i == 7 && !CHK) || (i == 8);
    endfunction
    function automatic logic e_sum(int i);
        return i == 8;
    endfunction

    // One dump: start pulse, ready asserted one cycle in rdy_period, beats logged
    task automatic run_dump(input int rdy_period, input bit repulse, input string tag);
        bit            hold;
        bit            seen_done;
        int            since_done;
        logic [AW-1:0] h_addr;
        logic [DW-1:0] h_data;
        logic          h_last;
        nb = 0; nd = 0; hold = 0; seen_done = 0; since_done = 0;
        h_addr = '0; h_data = '0; h_last = 1'b0;
        abort = 1'b0;
        dif.dump_ready = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            dif.dump_ready = ((c % rdy_period) == 0);
            start = repulse && (c == 6 || c == 7);
            if (hold) begin
                chk({tag, " hold valid"}, 32'(dif.dump_valid), 32'd1);
                chk({tag, " hold addr"},  32'(dif.dump_addr),  32'(h_addr));
                chk({tag, " hold data"},  32'(dif.dump_data),  32'(h_data));
                chk({tag, " hold last"},  32'(dif.dump_last),  32'(h_last));
            end
            if (dif.dump_valid && dif.dump_ready) begin
                if (nb < 16) begin
                    b_addr[nb] = dif.dump_addr;
                    b_data[nb] = dif.dump_data;
                    b_last[nb] = dif.dump_last;
                    b_sum[nb]  = dif.dump_sum;
                end
                nb++;
            end
            hold   = dif.dump_valid && !dif.dump_ready;
            h_addr = dif.dump_addr;
            h_data = dif.dump_data;
            h_last = dif.dump_last;
            if (done) begin
                nd++;
                seen_done = 1'b1;
            end
            if (seen_done) since_done++;
            if (since_done > 3) break;
            tick;
        end
        start = 1'b0;
        dif.dump_ready = 1'b0;
        chk({tag, " done seen"},  32'(seen_done), 32'd1);
        chk({tag, " beat count"}, 32'(nb), 32'(NB));
        chk({tag, " done count"}, 32'(nd), 32'd1);
        chk({tag, " busy after"}, 32'(busy), 32'd0);
        chk({tag, " inr holds"},  32'(inr),  32'd7);
        for (int i = 0; i < NB && i < nb; i++) begin
            chk($sformatf("%s beat%0d addr", tag, i), 32'(b_addr[i]), 32'(e_addr(i)));
            chk($sformatf("%s beat%0d data", tag, i), 32'(b_data[i]), 32'(e_data(i)));
            chk($sformatf("%s beat%0d last", tag, i), 32'(b_last[i]), 32'(e_last(i)));
            chk($sformatf("%s beat%0d sum",  tag, i), 32'(b_sum[i]),  32'(e_sum(i)));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " valid"}, 32'(dif.dump_valid), 32'd0);
        chk({tag, " addr"},  32'(dif.dump_addr),  32'd0);
        chk({tag, " data"},  32'(dif.dump_data),  32'd0);
        chk({tag, " last"},  32'(dif.dump_last),  32'd0);
        chk({tag, " sum"},   32'(dif.dump_sum),   32'd0);
        chk({tag, " busy"},  32'(busy),           32'd0);
        chk({tag, " done"},  32'(done),           32'd0);
        chk({tag, " inr"},   32'(inr),            32'd0);
    endtask

    initial begin
        bit stray;
        // Cycle-exact single dump with ready tied high, preceded by start+abort in IDLE
        tbl[0] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[1] = mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 8; k++) begin
            tbl[2 + 2 * k] = mk(0, 0, 1, 1, k, 1 << k, (k == 7) && !CHK, 0, 1, 0);
            tbl[3 + 2 * k] = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, (k == 7) && !CHK);
        end
        if (CHK) begin
            tbl[17] = mk(0, 0, 1, 1, 0, 'h00FF, 1, 1, 1, 0);
            tbl[18] = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
            tbl[19] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        end else begin
            tbl[18] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        end

        RST_N = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        dif.dump_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_all_zero("reset");
        @(negedge CLK);
        RST_N = 1'b1;
        tick;

        for (int i = 0; i < NT; i++) begin
            start = tbl[i].start;
            abort = tbl[i].abort;
            dif.dump_ready = tbl[i].ready;
            tick;
            chk($sformatf("vec%0d valid", i), 32'(dif.dump_valid), 32'(tbl[i].valid));
            chk($sformatf("vec%0d busy",  i), 32'(busy),           32'(tbl[i].busy));
            chk($sformatf("vec%0d done",  i), 32'(done),           32'(tbl[i].done));
            if (tbl[i].valid) begin
                chk($sformatf("vec%0d addr", i), 32'(dif.dump_addr), 32'(tbl[i].addr));
                chk($sformatf("vec%0d data", i), 32'(dif.dump_data), 32'(tbl[i].data));
                chk($sformatf("vec%0d last", i), 32'(dif.dump_last), 32'(tbl[i].last));
                chk($sformatf("vec%0d sum",  i), 32'(dif.dump_sum),  32'(tbl[i].sum));
            end
        end
        start = 1'b0;
        abort = 1'b0;

        // Asynchronous reset while beat 3 is on the bus
        dif.dump_ready = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (7) tick;
        chk("pre-reset valid", 32'(dif.dump_valid), 32'd1);
        chk("pre-reset addr",  32'(dif.dump_addr),  32'd3);
        #2;
        RST_N = 1'b0;
        #1;
        check_all_zero("async reset");
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        tick;
        chk("post-reset busy", 32'(busy), 32'd0);
        run_dump(1, 1'b0, "restart");

        // Back-pressure: ready high one cycle in three
        run_dump(3, 1'b0, "throttled");

        // Abort while beat 4 is stalled
        dif.dump_ready = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (8) tick;
        dif.dump_ready = 1'b0;
        tick;
        chk("abort beat4 valid", 32'(dif.dump_valid), 32'd1);
        chk("abort beat4 addr",  32'(dif.dump_addr),  32'd4);
        chk("abort beat4 data",  32'(dif.dump_data),  32'h10);
        tick;
        chk("abort beat4 still valid", 32'(dif.dump_valid), 32'd1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort valid", 32'(dif.dump_valid), 32'd0);
        chk("abort busy",  32'(busy),           32'd0);
        chk("abort last",  32'(dif.dump_last),  32'd0);
        chk("abort done",  32'(done),           32'd0);
        stray = 1'b0;
        dif.dump_ready = 1'b1;
        repeat (6) begin
            if (done || dif.dump_valid || busy) stray = 1'b1;
            tick;
        end
        chk("abort stays idle", 32'(stray), 32'd0);
        run_dump(1, 1'b0, "post-abort");

        // start re-pulsed mid-dump is ignored
        run_dump(1, 1'b1, "repulse");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
